// File: rtl/ring_store_pkg.sv
// ---------------------------------------------------------------------------
// ring_store_pkg
// Shared definitions for the recirculating ring word store:
//   - default widths for the top-level parameters
//   - seek engine state encoding
//   - address/counter width helper (never returns less than 1 bit)
// No ports; imported by ring_word_store and ring_word_assembler.
// ---------------------------------------------------------------------------
package ring_store_pkg;

    localparam int DEF_WORD_WIDTH = 8;
    localparam int DEF_WORD_COUNT = 32;
    localparam int DEF_DIN_WIDTH  = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEEK = 1'b1
    } seek_state_t;

    // Width of an index that spans n items. A single item still needs a
    // 1-bit field so that the declarations stay legal.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ring_word_assembler.sv
// ---------------------------------------------------------------------------
// ring_word_assembler
// Collects WORD_WIDTH/DIN_WIDTH narrow beats (LSB beat first) into a word.
// A gap in wr discards the partial word.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear of the partial word and beat counter
//   wr, din      write beat strobe and data
//   word_valid   high in the cycle that carries the final beat
//   word         complete assembled word (valid with word_valid)
// ---------------------------------------------------------------------------
module ring_word_assembler
    import ring_store_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int DIN_WIDTH  = DEF_DIN_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  wr,
    input  logic [DIN_WIDTH-1:0]  din,
    output logic                  word_valid,
    output logic [WORD_WIDTH-1:0] word
);

    localparam int BEATS = WORD_WIDTH / DIN_WIDTH;
    localparam int CNT_W = addr_width(BEATS);

    logic [CNT_W-1:0]      r_cnt;
    logic [WORD_WIDTH-1:0] r_asm;
    logic [WORD_WIDTH-1:0] w_shift;
    logic                  w_last;

    // Beats enter at the top and shift down, so after BEATS beats the first
    // one sits in the LSB slot. Stale bits from a discarded partial word are
    // shifted out before they can reach the finished word.
    generate
        if (BEATS > 1) begin : g_multi
            assign w_shift = {din, r_asm[WORD_WIDTH-1:DIN_WIDTH]};
        end else begin : g_single
            assign w_shift = din;
        end
    endgenerate

    assign w_last     = (r_cnt == CNT_W'(BEATS - 1));
    assign word_valid = wr && w_last;
    assign word       = w_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (clr) begin
            r_cnt <= '0;
            r_asm <= '0;
        end else if (wr) begin
            if (w_last) begin
                r_cnt <= '0;
                r_asm <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
                r_asm <= w_shift;
            end
        end else begin
            r_cnt <= '0;
            r_asm <= '0;
        end
    end

endmodule

// File: rtl/ring_word_store.sv
// ---------------------------------------------------------------------------
// ring_word_store
// Recirculating shift-register memory of WORD_COUNT x WORD_WIDTH words.
// The ring rotates one word per enabled cycle; the head word is always on
// dout. Words are written through a narrow beat port, and a seek engine
// rotates the ring until a requested address is at the head.
// Optional synchronous clear port when RING_CLEAR_EN is defined.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   en                  rotate by one word this cycle
//   wr, din             write beat strobe and data (LSB beat first)
//   seek_valid          load seek_addr as target and start seeking
//   seek_addr           target address
//   clr                 (RING_CLEAR_EN only) zero all words, abort seek
//   dout                word at the head (registered)
//   head_addr           address of the head word
//   seek_busy           seek in progress (ring rotates every cycle)
//   seek_done           one-cycle pulse when the target reached the head
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no seek; ring rotates only on en
// SEEK  | rotating one word per cycle until the target reaches the head
// ---------------------------------------------------------------------------
module ring_word_store
    import ring_store_pkg::*;
#(
    parameter int  WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int  WORD_COUNT = DEF_WORD_COUNT,
    parameter int  DIN_WIDTH  = DEF_DIN_WIDTH,
    localparam int AW         = addr_width(WORD_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  wr,
    input  logic [DIN_WIDTH-1:0]  din,
    input  logic                  seek_valid,
    input  logic [AW-1:0]         seek_addr,
`ifdef RING_CLEAR_EN
    input  logic                  clr,
`endif
    output logic [WORD_WIDTH-1:0] dout,
    output logic [AW-1:0]         head_addr,
    output logic                  seek_busy,
    output logic                  seek_done
);

    // Physical slot 0 is the head; slot i holds the word at head_addr+i.
    logic [WORD_WIDTH-1:0] r_ring [WORD_COUNT];
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_target;
    seek_state_t           r_state;
    logic                  r_done;

    seek_state_t           w_state_next;
    logic [AW-1:0]         w_target_next;
    logic [AW-1:0]         w_head_inc;
    logic [AW-1:0]         w_seek_tgt;
    logic                  w_done_next;
    logic                  w_rotate;
    logic                  w_clr;
    logic                  w_word_valid;
    logic [WORD_WIDTH-1:0] w_word;

`ifdef RING_CLEAR_EN
    assign w_clr = clr;
`else
    assign w_clr = 1'b0;
`endif

    ring_word_assembler #(
        .WORD_WIDTH (WORD_WIDTH),
        .DIN_WIDTH  (DIN_WIDTH)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_clr),
        .wr         (wr),
        .din        (din),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    assign w_head_inc = r_head + AW'(1);

    // A seek command issued from IDLE owns that cycle: en is ignored so a
    // hit on the current head really means zero rotations. While seeking the
    // ring always steps exactly one word per cycle.
    assign w_rotate = (r_state == SEEK) || (en && !seek_valid);

    // A retarget while seeking takes effect on the same edge.
    assign w_seek_tgt = seek_valid ? seek_addr : r_target;

    always_comb begin
        w_state_next  = r_state;
        w_target_next = r_target;
        w_done_next   = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (seek_valid) begin
                    w_target_next = seek_addr;
                    if (seek_addr == r_head) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next = SEEK;
                    end
                end
            end
            SEEK: begin
                w_target_next = w_seek_tgt;
                // Compare against the head address after this edge's rotation.
                if (w_head_inc == w_seek_tgt) begin
                    w_state_next = IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_done   <= 1'b0;
        end else if (w_clr) begin
            r_state  <= IDLE;
            r_target <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_target <= w_target_next;
            r_done   <= w_done_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head <= '0;
        end else if (!w_clr && w_rotate) begin
            r_head <= w_head_inc;
        end
    end

    // On a rotating write the new word lands in the slot leaving the head,
    // i.e. the tail, so it returns to the head after WORD_COUNT rotations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
                r_ring[i] <= '0;
            end
        end else if (w_clr) begin
            for (int i = 0; i < WORD_COUNT; i++) begin
                r_ring[i] <= '0;
            end
        end else if (w_rotate) begin
            for (int i = 0; i < WORD_COUNT - 1; i++) begin
                r_ring[i] <= r_ring[i+1];
            end
            r_ring[WORD_COUNT-1] <= w_word_valid ? w_word : r_ring[0];
        end else if (w_word_valid) begin
            r_ring[0] <= w_word;
        end
    end

    assign dout      = r_ring[0];
    assign head_addr = r_head;
    assign seek_busy = (r_state == SEEK);
    assign seek_done = r_done;

endmodule

// File: tb/tb_ring_word_store.sv
module tb_ring_word_store;

    localparam int WW    = 8;
    localparam int WC    = 32;
    localparam int DW    = 4;
    localparam int BEATS = WW / DW;
    localparam int AW    = $clog2(WC);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          wr;
    logic [DW-1:0] din;
    logic          seek_valid;
    logic [AW-1:0] seek_addr;
    logic [WW-1:0] dout;
    logic [AW-1:0] head_addr;
    logic          seek_busy;
    logic          seek_done;
`ifdef RING_CLEAR_EN
    logic          clr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: memory indexed by logical address plus a head pointer.
    logic [WW-1:0] m_mem [WC];
    int            m_head;
    logic [DW-1:0] m_beats [$];

    ring_word_store #(
        .WORD_WIDTH (WW),
        .WORD_COUNT (WC),
        .DIN_WIDTH  (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr         (wr),
        .din        (din),
        .seek_valid (seek_valid),
        .seek_addr  (seek_addr),
`ifdef RING_CLEAR_EN
        .clr        (clr),
`endif
        .dout       (dout),
        .head_addr  (head_addr),
        .seek_busy  (seek_busy),
        .seek_done  (seek_done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WC; i++) m_mem[i] = '0;
        m_head = 0;
        m_beats.delete();
    endtask

    // One edge of write/rotate behaviour from the bench's point of view.
    task automatic model_step(input bit rot);
        logic [WW-1:0] w;
        if (wr) begin
            m_beats.push_back(din);
            if (m_beats.size() == BEATS) begin
                w = '0;
                for (int k = 0; k < BEATS; k++) w[k*DW +: DW] = m_beats[k];
                m_mem[m_head] = w;
                m_beats.delete();
            end
        end else begin
            m_beats.delete();
        end
        if (rot) m_head = (m_head + 1) % WC;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle_plain();
        model_step(en);
        tick();
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_head"}, head_addr, m_head);
        chk({tag, "_dout"}, dout, m_mem[m_head]);
    endtask

    task automatic run_seek(input int tgt, input int rt_at, input int rt_tgt);
        int busy;
        int done;
        int start;
        int fin;
        logic first_done;
        busy  = 0;
        done  = 0;
        start = m_head;
        fin   = (rt_at >= 0) ? rt_tgt : tgt;
        en = 1'b0; wr = 1'b0;
        seek_valid = 1'b1;
        seek_addr  = AW'(tgt);
        model_step(1'b0);
        tick();
        seek_valid = 1'b0;
        first_done = seek_done;
        for (int c = 0; c < WC + 3; c++) begin
            if (c == rt_at) begin
                seek_valid = 1'b1;
                seek_addr  = AW'(rt_tgt);
            end else begin
                seek_valid = 1'b0;
            end
            if (seek_busy) begin
                busy++;
                model_step(1'b1);
            end
            if (seek_done) done++;
            tick();
        end
        seek_valid = 1'b0;
        chk("seek_busy_cycles", busy, (fin - start + WC) % WC);
        chk("seek_done_count", done, 1);
        chk("seek_head", head_addr, fin);
        chk("seek_dout", dout, m_mem[fin]);
        if (fin == start) chk("seek_hit_next", first_done, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wr = 1'b0; din = '0;
        seek_valid = 1'b0; seek_addr = '0;
`ifdef RING_CLEAR_EN
        clr = 1'b0;
`endif
        model_reset();
        tick();
        tick();
        chk("rst_dout", dout, 0);
        chk("rst_head", head_addr, 0);
        chk("rst_busy", seek_busy, 0);
        chk("rst_done", seek_done, 0);
        rst_n = 1'b1;

        // Plain rotation of an empty ring.
        en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            cycle_plain();
            chk("rot_head", head_addr, i);
            chk("rot_dout", dout, 0);
        end

        // Two-beat write without rotation, then a full lap.
        en = 1'b0; wr = 1'b1; din = 4'h5;
        cycle_plain();
        din = 4'hA;
        cycle_plain();
        chk("write_a5", dout, 8'hA5);
        wr = 1'b0; en = 1'b1;
        for (int i = 0; i < WC; i++) begin
            cycle_plain();
            chk_state("lap");
        end
        chk("lap_a5", dout, 8'hA5);
        chk("lap_head", head_addr, 4);

        // Interrupted write is discarded.
        en = 1'b0; wr = 1'b1; din = 4'h3;
        cycle_plain();
        wr = 1'b0;
        cycle_plain();
        wr = 1'b1; din = 4'h1;
        cycle_plain();
        din = 4'h2;
        cycle_plain();
        chk("discard_21", dout, 8'h21);
        wr = 1'b0;

        // Random writes and rotations against the model.
        for (int i = 0; i < 200; i++) begin
            en  = 1'($urandom_range(0, 1));
            wr  = ($urandom_range(0, 3) != 0);
            din = DW'($urandom);
            cycle_plain();
            chk_state("rand");
            chk("rand_busy", seek_busy, 0);
        end
        en = 1'b0; wr = 1'b0;

        // Seeks: head 5 -> 2, then a hit, then retarget, then random.
        en = 1'b1;
        for (int i = 0; i < WC && m_head != 5; i++) cycle_plain();
        en = 1'b0;
        chk("pre_seek_head", head_addr, 5);
        run_seek(2, -1, 0);
        run_seek(2, -1, 0);
        run_seek(20, 3, 10);
        for (int i = 0; i < 6; i++) begin
            run_seek(int'($urandom_range(0, WC - 1)), -1, 0);
        end

`ifdef RING_CLEAR_EN
        // Fill every word with 0xFF, then clear.
        for (int i = 0; i < WC; i++) begin
            wr = 1'b1; din = 4'hF; en = 1'b0;
            cycle_plain();
            en = 1'b1;
            cycle_plain();
        end
        wr = 1'b0; en = 1'b1;
        for (int i = 0; i < WC; i++) begin
            cycle_plain();
            chk("fill_ff", dout, 8'hFF);
        end
        clr = 1'b1; wr = 1'b1; din = 4'h7; en = 1'b1;
        model_reset_keep_head();
        tick();
        clr = 1'b0; wr = 1'b0;
        chk("clr_head_kept", head_addr, m_head);
        for (int i = 0; i < WC; i++) begin
            cycle_plain();
            chk("clr_zero", dout, 0);
        end
        en = 1'b0;
        // Clear aborts a seek without a done pulse.
        seek_valid = 1'b1; seek_addr = AW'((m_head + 12) % WC);
        model_step(1'b0);
        tick();
        seek_valid = 1'b0;
        model_step(1'b1);
        tick();
        clr = 1'b1;
        model_reset_keep_head();
        tick();
        clr = 1'b0;
        chk("clr_abort_busy", seek_busy, 0);
        chk("clr_abort_head", head_addr, m_head);
        tick();
        chk("clr_abort_done", seek_done, 0);
        chk("clr_abort_busy2", seek_busy, 0);
`endif

        // Reset in the middle of a seek and a partial write.
        en = 1'b0; wr = 1'b0;
        seek_valid = 1'b1; seek_addr = AW'((m_head + 9) % WC);
        model_step(1'b0);
        tick();
        seek_valid = 1'b0;
        wr = 1'b1; din = 4'h7;
        model_step(1'b1);
        tick();
        wr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("midrst_head", head_addr, 0);
        chk("midrst_dout", dout, 0);
        chk("midrst_busy", seek_busy, 0);
        chk("midrst_done", seek_done, 0);
        rst_n = 1'b1;
        wr = 1'b1; din = 4'h9;
        cycle_plain();
        din = 4'h6;
        cycle_plain();
        wr = 1'b0;
        chk("post_rst_69", dout, 8'h69);
        chk("post_rst_head", head_addr, 0);
        tick();
        chk("post_rst_done", seek_done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    task automatic model_reset_keep_head();
        for (int i = 0; i < WC; i++) m_mem[i] = '0;
        m_beats.delete();
    endtask

endmodule
